// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for button consumers: decoder state encoding and
// hold timings derived from the 12 MHz system clock.
package button_event_decoder_pkg;

    localparam int ONE_SECOND     = 12_000_000;
    localparam int QUARTER_SECOND = 3_000_000;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        HELD,
        REPEAT
    } state_t;

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle event strobes
// (press, release, short/long press, auto-repeat) plus a held level.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WAIT_LOW | after reset; waits for btn low so a held button is ignored
// IDLE     | button up, armed for the next press
// HELD     | button down, counting towards the long-press threshold
// REPEAT   | long press seen, emitting repeat strobes while held
//
// release_pulse / repeat_pulse carry the release / repeat events; the
// plain words are reserved keywords and cannot name ports.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_CYCLES   = ONE_SECOND,
    parameter int REPEAT_CYCLES = QUARTER_SECOND
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic step,
    output logic held
);

    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    // Counter is cleared on the press cycle, so terminal count LONG_CYCLES-1
    // lands long_press exactly LONG_CYCLES cycles after press.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Single FSM with hold counter; every output is registered and pulses
    // default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_LOW;
            cnt           <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            step          <= 1'b0;
            held          <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            step          <= 1'b0;
            held          <= 1'b0;
            case (state)
                WAIT_LOW: begin
                    if (!btn) state <= IDLE;
                end
                IDLE: begin
                    if (btn) begin
                        state <= HELD;
                        cnt   <= '0;
                        press <= 1'b1;
                        step  <= 1'b1;
                        held  <= 1'b1;
                    end
                end
                HELD: begin
                    if (!btn) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        short_press   <= 1'b1;
                    end else if (cnt == LONG_LAST) begin
                        state      <= REPEAT;
                        cnt        <= '0;
                        long_press <= 1'b1;
                        held       <= 1'b1;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        held <= 1'b1;
                    end
                end
                REPEAT: begin
                    if (!btn) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                    end else begin
                        held <= 1'b1;
                        if (REPEAT_CYCLES != 0 && cnt == REPEAT_LAST) begin
                            cnt          <= '0;
                            repeat_pulse <= 1'b1;
                            step         <= 1'b1;
                        end else if (REPEAT_CYCLES != 0) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= WAIT_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
